framebuffer_scanout: RTL and testbench
======================================

Name: framebuffer_scanout

Overview:
- Downstream consumer of the rasteriser's framebuffer writes.
- Scans a DISPLAY_WIDTH x DISPLAY_HEIGHT RGB565 framebuffer, replicating each pixel SCALE x SCALE, and emits VGA-style timing (hsync, vsync, de, rgb).
- Manages double buffering: selects which buffer is displayed, swaps buffers at vblank, and issues the frame_start pulse that launches the next render pass.

Parameters:
- DISPLAY_WIDTH, 100, framebuffer columns
- DISPLAY_HEIGHT, 100, framebuffer rows
- SCALE, 4, output pixels/lines per framebuffer pixel/row
- FRAMEBUFFER_DATA_BITS, 16, RGB565 pixel width
- FRAMEBUFFER_ADDR_BITS, $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT), read address width
- H_FRONT, 16, horizontal front porch (clk cycles)
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock, one output pixel per cycle
- rst  in  1  reset
- fb_rd_addr  out  FRAMEBUFFER_ADDR_BITS  framebuffer read address
- fb_rd_data  in  FRAMEBUFFER_DATA_BITS  read data, valid 1 cycle after fb_rd_addr
- fb_display_sel  out  1  buffer being scanned; the renderer writes buffer ~fb_display_sel
- frame_done  in  1  single-cycle pulse from the rasteriser when a render pass completes
- frame_start  out  1  single-cycle pulse telling the rasteriser to render into the back buffer
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  display enable (visible pixel)
- rgb  out  16  pixel, RGB565 {r[4:0], g[5:0], b[4:0]}
- dropped_frames  out  8  saturating count of vblanks with no completed render

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values: hsync=1, vsync=1, de=0, rgb=0, frame_start=0, fb_display_sel=0, fb_rd_addr=0, dropped_frames=0. Counters h=0, v=0. render_done_flag=1, so the first vblank swaps buffers.
- Timing:
  - H_VIS = DISPLAY_WIDTH*SCALE; H_TOTAL = H_VIS + H_FRONT + H_SYNC + H_BACK.
  - V_VIS = DISPLAY_HEIGHT*SCALE; V_TOTAL = V_VIS + V_FRONT + V_SYNC + V_BACK.
  - h increments every cycle and wraps at H_TOTAL-1 to 0. v increments on each h wrap and wraps at V_TOTAL-1 to 0.
- Address generation:
  - No divider. Column sub-counter 0..SCALE-1 advances fb column; line sub-counter advances fb row.
  - fb_rd_addr = col + DISPLAY_WIDTH*row for visible (h,v); registered; 0 outside visible.
  - Row base accumulated by adding DISPLAY_WIDTH, not multiplied.
- Pipeline:
  - Fixed 2-cycle latency from counter position (h,v) to its outputs: cycle 1 registers fb_rd_addr, cycle 2 registers rgb from fb_rd_data.
  - hsync/vsync/de are delayed identically, so output-visible alignment is exact.
  - de = (h < H_VIS) && (v < V_VIS).
  - hsync = 0 for h in [H_VIS+H_FRONT, H_VIS+H_FRONT+H_SYNC).
  - vsync = 0 for v in [V_VIS+V_FRONT, V_VIS+V_FRONT+V_SYNC).
  - rgb = fb_rd_data when de, else 0.
- Buffer/frame control (evaluated on the counter cycle h=0, v=V_VIS, i.e. vblank start):
  - render_done_flag sets on any frame_done pulse. A frame_done on the vblank-start cycle itself counts.
  - If flag=1: toggle fb_display_sel, pulse frame_start for exactly 1 cycle (the next cycle), clear flag.
  - If flag=0: no toggle, no frame_start, dropped_frames += 1 (saturates at 255).
  - fb_display_sel changes only during vblank, never mid-visible.
  - frame_done during the frame_start cycle sets the flag for the following vblank.
- Reset mid-frame: all outputs take reset values the cycle after rst is sampled; scanning restarts at (0,0) and the pipeline flushes (de=0 until new data arrives).
- Arithmetic: counters sized by $clog2 of their totals; no signed math.

Test Plan:
Tests use W=4, H=3, SCALE=2, H_FRONT=1, H_SYNC=2, H_BACK=1, V_FRONT=1, V_SYNC=2, V_BACK=1, giving H_TOTAL=12 and V_TOTAL=10. The framebuffer model returns data = addr + 256*sel.
- Reset for 3 cycles -> hsync=1, vsync=1, de=0, rgb=0, frame_start=0, fb_display_sel=0, dropped_frames=0.
- Free run, buffer 1 displayed -> de high 8 cycles per line:
  - lines 0-1 rgb 0x100,0x100,0x101,0x101,0x102,0x102,0x103,0x103
  - lines 2-3 start at 0x104
  - lines 4-5 end at 0x10B
- Sync check -> hsync low for exactly 2 cycles, starting 1 cycle after de falls; vsync low during lines 7-8; 6 de-lines per frame.
- First vblank after reset -> frame_start one-cycle pulse, fb_display_sel 0->1. No frame_done during next frame -> next vblank has no pulse, sel stays 1, dropped_frames=1.
- frame_done asserted exactly on the vblank-start counter cycle -> swap to 0 and frame_start pulse that vblank; dropped_frames unchanged.
- rst asserted mid-line 3 -> next cycle all outputs at reset values; after release, first de rises 2 cycles after counter restart with rgb=0x000.

Source files
------------

// File: rtl/framebuffer_scanout.sv
// Framebuffer scan-out: VGA-style timing with SCALE x SCALE pixel replication,
// a two-stage address/data pipeline and double-buffer swap control at vblank.
module framebuffer_scanout #(
    parameter int unsigned DISPLAY_WIDTH         = 100,
    parameter int unsigned DISPLAY_HEIGHT        = 100,
    parameter int unsigned SCALE                 = 4,
    parameter int unsigned FRAMEBUFFER_DATA_BITS = 16,
    parameter int unsigned FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT),
    parameter int unsigned H_FRONT               = 16,
    parameter int unsigned H_SYNC                = 96,
    parameter int unsigned H_BACK                = 48,
    parameter int unsigned V_FRONT               = 10,
    parameter int unsigned V_SYNC                = 2,
    parameter int unsigned V_BACK                = 33
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] fb_rd_addr,
    input  logic [FRAMEBUFFER_DATA_BITS-1:0] fb_rd_data,
    output logic                             fb_display_sel,
    input  logic                             frame_done,
    output logic                             frame_start,
    output logic                             hsync,
    output logic                             vsync,
    output logic                             de,
    output logic [15:0]                      rgb,
    output logic [7:0]                       dropped_frames
);
    localparam int unsigned H_VIS    = DISPLAY_WIDTH * SCALE;
    localparam int unsigned H_TOTAL  = H_VIS + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_VIS    = DISPLAY_HEIGHT * SCALE;
    localparam int unsigned V_TOTAL  = V_VIS + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned SW       = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int unsigned AW       = FRAMEBUFFER_ADDR_BITS;
    localparam int unsigned HS_START = H_VIS + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VIS + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [SW-1:0] csub_q, csub_d, lsub_q, lsub_d;
    logic [AW-1:0] col_q, col_d, row_base_q, row_base_d, addr_q, addr_d;
    logic          de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
    logic [15:0]   rgb_q, rgb_d;
    logic          sel_q, sel_d, fs_q, fs_d, flag_q, flag_d;
    logic [7:0]    drop_q, drop_d;
    logic          h_wrap, v_wrap, h_vis, v_vis, vblank_start, pending;

    always_comb begin
        h_wrap       = (h_q == HW'(H_TOTAL - 1));
        v_wrap       = (v_q == VW'(V_TOTAL - 1));
        h_vis        = (h_q < HW'(H_VIS));
        v_vis        = (v_q < VW'(V_VIS));
        vblank_start = (h_q == '0) && (v_q == VW'(V_VIS));
        pending      = flag_q | frame_done;

        h_d = h_wrap ? '0 : h_q + HW'(1);
        v_d = v_q;
        if (h_wrap) v_d = v_wrap ? '0 : v_q + VW'(1);

        // Column/row tracked by sub-counters; the row base steps by DISPLAY_WIDTH.
        csub_d = csub_q;
        col_d  = col_q;
        if (h_wrap) begin
            csub_d = '0;
            col_d  = '0;
        end else if (h_vis) begin
            if (csub_q == SW'(SCALE - 1)) begin
                csub_d = '0;
                col_d  = col_q + AW'(1);
            end else begin
                csub_d = csub_q + SW'(1);
            end
        end

        lsub_d     = lsub_q;
        row_base_d = row_base_q;
        if (h_wrap) begin
            if (v_wrap) begin
                lsub_d     = '0;
                row_base_d = '0;
            end else if (v_vis) begin
                if (lsub_q == SW'(SCALE - 1)) begin
                    lsub_d     = '0;
                    row_base_d = row_base_q + AW'(DISPLAY_WIDTH);
                end else begin
                    lsub_d = lsub_q + SW'(1);
                end
            end
        end

        addr_d = (h_vis && v_vis) ? col_q + row_base_q : '0;
        de1_d  = h_vis && v_vis;
        hs1_d  = !((h_q >= HW'(HS_START)) && (h_q < HW'(HS_END)));
        vs1_d  = !((v_q >= VW'(VS_START)) && (v_q < VW'(VS_END)));

        rgb_d = de1_q ? 16'(fb_rd_data) : '0;
        de_d  = de1_q;
        hs_d  = hs1_q;
        vs_d  = vs1_q;

        flag_d = pending;
        sel_d  = sel_q;
        fs_d   = 1'b0;
        drop_d = drop_q;
        if (vblank_start) begin
            if (pending) begin
                sel_d  = ~sel_q;
                fs_d   = 1'b1;
                flag_d = 1'b0;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q        <= '0;
            v_q        <= '0;
            csub_q     <= '0;
            col_q      <= '0;
            lsub_q     <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            de1_q      <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            de_q       <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            rgb_q      <= '0;
            sel_q      <= 1'b0;
            fs_q       <= 1'b0;
            flag_q     <= 1'b1;
            drop_q     <= '0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            csub_q     <= csub_d;
            col_q      <= col_d;
            lsub_q     <= lsub_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            de1_q      <= de1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            de_q       <= de_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            rgb_q      <= rgb_d;
            sel_q      <= sel_d;
            fs_q       <= fs_d;
            flag_q     <= flag_d;
            drop_q     <= drop_d;
        end
    end

    assign fb_rd_addr     = addr_q;
    assign fb_display_sel = sel_q;
    assign frame_start    = fs_q;
    assign hsync          = hs_q;
    assign vsync          = vs_q;
    assign de             = de_q;
    assign rgb            = rgb_q;
    assign dropped_frames = drop_q;
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout: a position-based reference model pushes
// expected video per cycle, a monitor pops and compares against the DUT outputs.
module tb_framebuffer_scanout;
    localparam int W = 4, H = 3, S = 2;
    localparam int HF = 1, HSY = 2, HB = 1, VF = 1, VSY = 2, VB = 1;
    localparam int HVIS = W * S, HTOT = HVIS + HF + HSY + HB;
    localparam int VVIS = H * S, VTOT = VVIS + VF + VSY + VB;
    localparam int FRAME = HTOT * VTOT;
    localparam int AB = $clog2(W * H);

    logic          clk = 1'b0, rst = 1'b1, frame_done = 1'b0;
    logic [AB-1:0] fb_rd_addr;
    logic [15:0]   fb_rd_data;
    logic          fb_display_sel, frame_start, hsync, vsync, de;
    logic [15:0]   rgb;
    logic [7:0]    dropped_frames;

    framebuffer_scanout #(
        .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .SCALE(S), .FRAMEBUFFER_DATA_BITS(16),
        .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst(rst), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .fb_display_sel(fb_display_sel), .frame_done(frame_done), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .dropped_frames(dropped_frames)
    );

    // Framebuffer model: each buffer holds addr + 256*buffer.
    assign fb_rd_data = 16'(fb_rd_addr) + (fb_display_sel ? 16'h100 : 16'h000);

    always #5 clk = ~clk;

    typedef struct { logic de; logic hs; logic vs; logic [15:0] rgb; } vid_t;
    vid_t exp_q[$];
    int   mh = 0, mv = 0, m_drop = 0;
    logic m_sel = 1'b0, m_fs = 1'b0, m_flag = 1'b1;
    bit   started = 1'b0;
    int   n_cmp = 0, n_bad = 0;

    function automatic vid_t expect_at(int h, int v, logic sel);
        vid_t e;
        e.de  = (h < HVIS) && (v < VVIS);
        e.hs  = !(h >= HVIS + HF && h < HVIS + HF + HSY);
        e.vs  = !(v >= VVIS + VF && v < VVIS + VF + VSY);
        e.rgb = e.de ? 16'(h / S + W * (v / S) + (sel ? 256 : 0)) : 16'h0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances at every clock edge from the sampled inputs.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            mh = 0; mv = 0; m_sel = 1'b0; m_fs = 1'b0; m_flag = 1'b1; m_drop = 0;
            exp_q.delete();
            exp_q.push_back(expect_at(HVIS, 0, 1'b0));
            exp_q.push_back(expect_at(HVIS, 0, 1'b0));
            started = 1'b1;
        end else if (started) begin
            m_fs = 1'b0;
            if (mh == 0 && mv == VVIS) begin
                if (m_flag || frame_done) begin
                    m_sel = ~m_sel; m_fs = 1'b1; m_flag = 1'b0;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end else if (frame_done) begin
                m_flag = 1'b1;
            end
            exp_q.push_back(expect_at(mh, mv, m_sel));
            mh = (mh + 1) % HTOT;
            if (mh == 0) mv = (mv + 1) % VTOT;
        end
    end

    // Monitor: pops one expectation for each output cycle.
    initial forever begin
        vid_t e;
        @(negedge clk);
        if (started && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("de", int'(de), int'(e.de));
            chk("hsync", int'(hsync), int'(e.hs));
            chk("vsync", int'(vsync), int'(e.vs));
            chk("rgb", int'(rgb), int'(e.rgb));
            chk("fb_display_sel", int'(fb_display_sel), int'(m_sel));
            chk("frame_start", int'(frame_start), int'(m_fs));
            chk("dropped_frames", int'(dropped_frames), m_drop);
        end
    end

    // mode 0: no frame_done, 1: random pulses, 2: pulse exactly on vblank start
    task automatic run_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            case (mode)
                1:       frame_done = ($urandom_range(0, 39) == 0);
                2:       frame_done = (mh == 0 && mv == VVIS);
                default: frame_done = 1'b0;
            endcase
        end
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    task automatic wait_pos(input int h, input int v);
        int budget = 2 * FRAME;
        while (!(mh == h && mv == v) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_pos: position (%0d,%0d) not reached, at (%0d,%0d)", h, v, mh, mv);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_cycles(2 * FRAME, 0);
        run_cycles(FRAME, 2);
        run_cycles(8 * FRAME, 1);
        wait_pos(5, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_cycles(3 * FRAME, 1);
        run_cycles(FRAME, 2);
        run_cycles(260 * FRAME, 0);
        run_cycles(2 * FRAME, 1);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
